// File: rtl/ram_arbiter_if.sv
// Request/response bundle between the two client ports, the arbiter and the RAM.
// The slave modport is the arbiter's view; master is the environment's view.
interface ram_arbiter_if;
    logic        fetchReqIn;
    logic [31:0] fetchAddrIn;
    logic        fetchAckOut;
    logic [31:0] fetchDataOut;
    logic        fetchErrOut;

    logic        memReqIn;
    logic [31:0] memAddrIn;
    logic [31:0] memDataIn;
    logic        memRwIn;
    logic        memAckOut;
    logic [31:0] memDataOut;
    logic        memErrOut;

    logic [31:0] ramAddrOut;
    logic [31:0] ramDataOut;
    logic        ramRwOut;
    logic        ramTriggerOut;
    logic [31:0] ramDataIn;
    logic        ramReadyIn;

    logic        busyOut;

    modport slave (
        input  fetchReqIn, fetchAddrIn, memReqIn, memAddrIn, memDataIn, memRwIn,
               ramDataIn, ramReadyIn,
        output fetchAckOut, fetchDataOut, fetchErrOut, memAckOut, memDataOut, memErrOut,
               ramAddrOut, ramDataOut, ramRwOut, ramTriggerOut, busyOut
    );

    modport master (
        output fetchReqIn, fetchAddrIn, memReqIn, memAddrIn, memDataIn, memRwIn,
               ramDataIn, ramReadyIn,
        input  fetchAckOut, fetchDataOut, fetchErrOut, memAckOut, memDataOut, memErrOut,
               ramAddrOut, ramDataOut, ramRwOut, ramTriggerOut, busyOut
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter of a fetch and a data port onto a toggle-triggered asynchronous RAM.
// Define RAM_ARB_TIMEOUT_EN to bound the wait for ramReadyIn to TIMEOUT_CYCLES cycles.
module ram_arbiter #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic          clkIn,
    input logic          nResetIn,
    ram_arbiter_if.slave bus
);
    localparam int            BW         = $clog2(SYNC_STAGES + 2);
    localparam logic [BW-1:0] BLANK_LAST = BW'(SYNC_STAGES);

    // Supported range: SYNC_STAGES 2..3, TIMEOUT_CYCLES >= 2.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || TIMEOUT_CYCLES < 2) begin : g_unsupported_cfg
    end

    typedef enum logic [2:0] {IDLE, SETUP, BLANK, WAIT_READY, RESP} state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_mem_q;
    logic                   port_mem_q;
    logic [BW-1:0]          blank_cnt_q;
    logic [31:0]            ramAddr_q;
    logic [31:0]            ramData_q;
    logic                   ramRw_q;
    logic                   trig_q;
    logic                   busy_q;
    logic                   fetchAck_q;
    logic                   fetchErr_q;
    logic [31:0]            fetchData_q;
    logic                   memAck_q;
    logic                   memErr_q;
    logic [31:0]            memData_q;
`ifdef RAM_ARB_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0]            tmo_cnt_q;
`endif

    logic        ready_sync;
    logic        any_req;
    logic        grant_mem;
    logic [31:0] win_addr;
    logic        out_of_range;

    assign ready_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        any_req      = bus.fetchReqIn | bus.memReqIn;
        // Data port wins a tie only when fetch was granted last.
        grant_mem    = bus.memReqIn & (~bus.fetchReqIn | ~last_mem_q);
        win_addr     = grant_mem ? bus.memAddrIn : bus.fetchAddrIn;
        out_of_range = (win_addr[31:10] != 22'd0) || (win_addr[9:0] > 10'd1020);
    end

    // Ready is asynchronous; resetting the chain to 1 matches an idle RAM.
    always_ff @(posedge clkIn) begin
        if (!nResetIn) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.ramReadyIn};
        end
    end

    always_ff @(posedge clkIn) begin
        if (!nResetIn) begin
            state_q     <= IDLE;
            last_mem_q  <= 1'b1;
            port_mem_q  <= 1'b0;
            blank_cnt_q <= '0;
            ramAddr_q   <= '0;
            ramData_q   <= '0;
            ramRw_q     <= 1'b0;
            trig_q      <= 1'b0;
            busy_q      <= 1'b0;
            fetchAck_q  <= 1'b0;
            fetchErr_q  <= 1'b0;
            fetchData_q <= '0;
            memAck_q    <= 1'b0;
            memErr_q    <= 1'b0;
            memData_q   <= '0;
`ifdef RAM_ARB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            fetchAck_q <= 1'b0;
            memAck_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        port_mem_q <= grant_mem;
                        last_mem_q <= grant_mem;
                        busy_q     <= 1'b1;
                        if (out_of_range) begin
                            // Rejected without touching the RAM pins.
                            state_q <= RESP;
                            if (grant_mem) begin
                                memAck_q  <= 1'b1;
                                memErr_q  <= 1'b1;
                                memData_q <= '0;
                            end else begin
                                fetchAck_q  <= 1'b1;
                                fetchErr_q  <= 1'b1;
                                fetchData_q <= '0;
                            end
                        end else begin
                            ramAddr_q <= win_addr;
                            ramData_q <= grant_mem ? bus.memDataIn : 32'd0;
                            ramRw_q   <= grant_mem & bus.memRwIn;
                            state_q   <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    trig_q      <= ~trig_q;
                    blank_cnt_q <= '0;
                    state_q     <= BLANK;
                end
                BLANK: begin
                    // Synced ready still shows the pre-trigger level here.
                    if (blank_cnt_q == BLANK_LAST) begin
                        state_q <= WAIT_READY;
`ifdef RAM_ARB_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end else begin
                        blank_cnt_q <= blank_cnt_q + 1'b1;
                    end
                end
                WAIT_READY: begin
                    if (ready_sync) begin
                        state_q <= RESP;
                        if (port_mem_q) begin
                            memAck_q <= 1'b1;
                            memErr_q <= 1'b0;
                            if (!ramRw_q) memData_q <= bus.ramDataIn;
                        end else begin
                            fetchAck_q  <= 1'b1;
                            fetchErr_q  <= 1'b0;
                            fetchData_q <= bus.ramDataIn;
                        end
                    end
`ifdef RAM_ARB_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_LAST) begin
                        state_q <= RESP;
                        if (port_mem_q) begin
                            memAck_q  <= 1'b1;
                            memErr_q  <= 1'b1;
                            memData_q <= '0;
                        end else begin
                            fetchAck_q  <= 1'b1;
                            fetchErr_q  <= 1'b1;
                            fetchData_q <= '0;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.fetchAckOut   = fetchAck_q;
    assign bus.fetchDataOut  = fetchData_q;
    assign bus.fetchErrOut   = fetchErr_q;
    assign bus.memAckOut     = memAck_q;
    assign bus.memDataOut    = memData_q;
    assign bus.memErrOut     = memErr_q;
    assign bus.ramAddrOut    = ramAddr_q;
    assign bus.ramDataOut    = ramData_q;
    assign bus.ramRwOut      = ramRw_q;
    assign bus.ramTriggerOut = trig_q;
    assign bus.busyOut       = busy_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural toggle-triggered RAM model.
// Build with +define+RAM_ARB_TIMEOUT_EN to exercise the bounded wait.
module tb_ram_arbiter;
    logic clk;
    logic rst_n;

    ram_arbiter_if bus ();

    ram_arbiter #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (256)
    ) dut (
        .clkIn    (clk),
        .nResetIn (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          trig_cnt = 0;
    bit          ready_en = 1'b1;
    logic [31:0] mem [256];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // RAM: each trigger edge drops ready, performs the access, and raises ready within a clock.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]   = 32'h1111_1111;
        mem[4]   = 32'hDEAD_BEEF;
        mem[255] = 32'hA5A5_A5A5;
        bus.ramReadyIn = 1'b1;
        bus.ramDataIn  = 32'h0;
        forever begin
            @(bus.ramTriggerOut);
            bus.ramReadyIn = 1'b0;
            trig_cnt++;
            #1;
            if (!$isunknown(bus.ramAddrOut)) begin
                if (bus.ramRwOut === 1'b1) mem[bus.ramAddrOut[9:2]] = bus.ramDataOut;
                else                       bus.ramDataIn = mem[bus.ramAddrOut[9:2]];
            end
            #2;
            if (ready_en) bus.ramReadyIn = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          port;      // 0 fetch, 1 data
        bit          rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        bit          exp_err;
        int          exp_lat;
        int          exp_trig;
    } vec_t;

    vec_t vecs [8];

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          k;
        bit          got;
        int          t0;
        logic [31:0] d;
        logic        e;
        logic        other;
        logic        rw;
        t0 = trig_cnt;
        if (v.port) begin
            bus.memAddrIn = v.addr;
            bus.memDataIn = v.wdata;
            bus.memRwIn   = v.rw;
            bus.memReqIn  = 1'b1;
        end else begin
            bus.fetchAddrIn = v.addr;
            bus.fetchReqIn  = 1'b1;
        end
        k   = 0;
        got = 1'b0;
        while (!got && k < 50) begin
            tick();
            k++;
            if (v.port ? bus.memAckOut : bus.fetchAckOut) got = 1'b1;
        end
        d     = v.port ? bus.memDataOut : bus.fetchDataOut;
        e     = v.port ? bus.memErrOut  : bus.fetchErrOut;
        other = v.port ? bus.fetchAckOut : bus.memAckOut;
        rw    = bus.ramRwOut;
        bus.memReqIn   = 1'b0;
        bus.fetchReqIn = 1'b0;
        chk($sformatf("v%0d_ack", idx), 32'(got), 32'd1);
        chk($sformatf("v%0d_latency", idx), 32'(k), 32'(v.exp_lat));
        chk($sformatf("v%0d_err", idx), 32'(e), 32'(v.exp_err));
        if (v.exp_err || !v.rw) chk($sformatf("v%0d_data", idx), d, v.exp_data);
        if (!v.exp_err) chk($sformatf("v%0d_ramrw", idx), 32'(rw), 32'(v.rw));
        chk($sformatf("v%0d_other_ack", idx), 32'(other), 32'd0);
        chk($sformatf("v%0d_trig_edges", idx), 32'(trig_cnt - t0), 32'(v.exp_trig));
        tick();
        chk($sformatf("v%0d_ack_pulse", idx),
            32'(v.port ? bus.memAckOut : bus.fetchAckOut), 32'd0);
        tick();
    endtask

    initial begin
        int   order [4];
        int   n_acks;
        int   k;
        bit   stray;
        bit   still_busy;

        bus.fetchReqIn  = 1'b0;
        bus.fetchAddrIn = 32'h0;
        bus.memReqIn    = 1'b0;
        bus.memAddrIn   = 32'h0;
        bus.memDataIn   = 32'h0;
        bus.memRwIn     = 1'b0;
        rst_n           = 1'b0;
        tick();
        tick();
        chk("rst_busy",      32'(bus.busyOut),       32'd0);
        chk("rst_fetch_ack", 32'(bus.fetchAckOut),   32'd0);
        chk("rst_mem_ack",   32'(bus.memAckOut),     32'd0);
        chk("rst_trigger",   32'(bus.ramTriggerOut), 32'd0);
        chk("rst_ram_rw",    32'(bus.ramRwOut),      32'd0);
        chk("rst_ram_addr",  bus.ramAddrOut,         32'd0);
        chk("rst_fetch_dat", bus.fetchDataOut,       32'd0);
        chk("rst_mem_dat",   bus.memDataOut,         32'd0);
        rst_n = 1'b1;
        tick();

        //          port  rw    addr           wdata          exp_data       err   lat trig
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 6, 1};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0,         1'b0, 6, 1};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         32'h1234_5678, 1'b0, 6, 1};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         32'hA5A5_A5A5, 1'b0, 6, 1};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_03FE, 32'h0,         32'h0,         1'b1, 1, 0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,         32'h0,         1'b1, 1, 0};
        vecs[6] = '{1'b0, 1'b0, 32'h1000_0010, 32'h0,         32'h0,         1'b1, 1, 0};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'h1234_5678, 1'b0, 6, 1};
        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Both ports held: fetch wins the first tie after reset, then alternation.
        do_reset();
        bus.fetchAddrIn = 32'h0000_0010;
        bus.memAddrIn   = 32'h0000_0020;
        bus.memRwIn     = 1'b0;
        bus.fetchReqIn  = 1'b1;
        bus.memReqIn    = 1'b1;
        n_acks = 0;
        k      = 0;
        while (n_acks < 4 && k < 100) begin
            tick();
            k++;
            if (bus.fetchAckOut && bus.memAckOut) chk("rr_dual_ack", 32'd1, 32'd0);
            if (bus.fetchAckOut) begin order[n_acks] = 0; n_acks++; end
            else if (bus.memAckOut) begin order[n_acks] = 1; n_acks++; end
        end
        bus.fetchReqIn = 1'b0;
        bus.memReqIn   = 1'b0;
        chk("rr_ack_count", 32'(n_acks), 32'd4);
        for (int i = 0; i < n_acks; i++) chk($sformatf("rr_grant%0d", i), 32'(order[i]), 32'(i % 2));
        tick();
        tick();

        // Reset while in BLANK with the trigger high.
        do_reset();
        bus.memAddrIn = 32'h0000_0040;
        bus.memDataIn = 32'hCAFE_F00D;
        bus.memRwIn   = 1'b1;
        bus.memReqIn  = 1'b1;
        tick();
        tick();
        chk("blank_trigger_high", 32'(bus.ramTriggerOut), 32'd1);
        chk("blank_busy",         32'(bus.busyOut),       32'd1);
        rst_n        = 1'b0;
        bus.memReqIn = 1'b0;
        tick();
        chk("midrst_trigger", 32'(bus.ramTriggerOut), 32'd0);
        chk("midrst_ram_rw",  32'(bus.ramRwOut),      32'd0);
        chk("midrst_busy",    32'(bus.busyOut),       32'd0);
        chk("midrst_ack",     32'(bus.memAckOut),     32'd0);
        rst_n = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.memAckOut || bus.fetchAckOut || bus.busyOut) stray = 1'b1;
        end
        chk("midrst_no_ack", 32'(stray), 32'd0);
        chk("midrst_mem0",   mem[0],  32'h1111_1111);
        chk("midrst_mem16",  mem[16], 32'hCAFE_F00D);

        // RAM never signals ready.
        ready_en        = 1'b0;
        bus.fetchAddrIn = 32'h0000_0044;
        bus.fetchReqIn  = 1'b1;
`ifdef RAM_ARB_TIMEOUT_EN
        k     = 0;
        stray = 1'b0;
        while (!stray && k < 400) begin
            tick();
            k++;
            if (bus.fetchAckOut) stray = 1'b1;
        end
        chk("tmo_ack",     32'(stray), 32'd1);
        chk("tmo_latency", 32'(k), 32'd261);
        chk("tmo_err",     32'(bus.fetchErrOut),  32'd1);
        chk("tmo_data",    bus.fetchDataOut,      32'd0);
        bus.fetchReqIn = 1'b0;
        tick();
        tick();
        chk("tmo_idle",    32'(bus.busyOut), 32'd0);
`else
        still_busy = 1'b1;
        stray      = 1'b0;
        tick();
        for (int i = 0; i < 400; i++) begin
            tick();
            if (!bus.busyOut) still_busy = 1'b0;
            if (bus.fetchAckOut) stray = 1'b1;
        end
        chk("notmo_busy",   32'(still_busy), 32'd1);
        chk("notmo_no_ack", 32'(stray),      32'd0);
        bus.fetchReqIn = 1'b0;
        do_reset();
        chk("notmo_reset_idle", 32'(bus.busyOut), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of flops synchronizing ramReadyIn (legal 2..3).
REQ-002 Parameter: TIMEOUT_CYCLES, default 256, WAIT_READY cycle limit, used only when RAM_ARB_TIMEOUT_EN is defined.
REQ-003 Clock and reset: one clock; reset is synchronous and active-low.
REQ-004 clkIn  input  1  sole clock; all state updates on its rising edge.
REQ-005 nResetIn  input  1  synchronous active-low reset.
REQ-006 fetchReqIn  input  1  fetch port read request, held until fetchAckOut.
REQ-007 fetchAddrIn  input  32  fetch byte address.
REQ-008 fetchAckOut  output  1  one-cycle completion pulse, fetch port.
REQ-009 fetchDataOut  output  32  fetch read data, valid while fetchAckOut=1.
REQ-010 fetchErrOut  output  1  error flag, valid while fetchAckOut=1.
REQ-011 memReqIn / memAddrIn[31:0] / memDataIn[31:0] / memRwIn  input  1/32/32/1  data port request, address, write data, 0=read 1=write.
REQ-012 memAckOut / memDataOut[31:0] / memErrOut  output  1/32/1  data port completion pulse, read data, error flag.
REQ-013 ramAddrOut / ramDataOut / ramRwOut  output  32/32/1  registered RAM address, write data, direction.
REQ-014 ramTriggerOut  output  1  RAM start; each level change (either edge) starts one access.
REQ-015 ramDataIn  input  32  RAM read data.
REQ-016 ramReadyIn  input  1  asynchronous RAM done; drops at the trigger edge, rises on completion.
REQ-017 busyOut  output  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, SETUP, BLANK, WAIT_READY, RESP.
REQ-019 IDLE: on any pending request, latch the winner's addr/data/rw and the port id, then go to SETUP.
REQ-020 Arbitration: round-robin; when both ports request, grant the port not granted last; a lone requester always wins.
REQ-021 Fetch grants force rw=0.
REQ-022 Range check at latch: addr[31:10]!=0 or addr[9:0]>1020 is out of range.
REQ-023 Out-of-range request: go IDLE->RESP directly, with no trigger toggle, data=0, err=1.
REQ-024 SETUP: drive ramAddrOut/ramDataOut/ramRwOut from the latched values for one full cycle.
REQ-025 At the end of SETUP, toggle ramTriggerOut, which guarantees one cycle of setup before the edge.
REQ-026 BLANK: hold for exactly SYNC_STAGES+1 cycles and ignore synced ready, then go to WAIT_READY.
REQ-027 WAIT_READY: go to RESP on the first cycle synced ramReadyIn=1.
REQ-028 On a WAIT_READY->RESP read, register ramDataIn into the granted port's data output.
REQ-029 RESP: for one cycle, assert the granted port's ack with err=0, or err=1 per REQ-023/REQ-034; then go to IDLE. The other port's ack stays 0.
REQ-030 Latency: with the RAM finishing within one clock, ack is asserted exactly in cycle N+4+SYNC_STAGES, where N is the cycle the request is latched in IDLE.
REQ-031 A request held high through its ack is treated as a new request and re-arbitrates in the next IDLE cycle; no back-to-back grants occur inside RESP.
REQ-032 A request dropped after latch still completes, and its ack is still pulsed.
REQ-033 Outputs to the RAM change only in IDLE/SETUP; they are stable from SETUP until the next IDLE.

Reset
REQ-034 On nResetIn=0 at a clock edge, apply these values: FSM=IDLE; all acks, errs and busyOut=0; fetchDataOut, memDataOut, ramAddrOut, ramDataOut=0; ramRwOut=0; ramTriggerOut=0; synchronizer flops=1; last-grant=data port, so the fetch port wins the first tie.
REQ-035 Reset mid-access with ramTriggerOut=1 produces a trigger edge to the RAM. ramRwOut is forced to 0 in the same cycle, so that spurious access is a harmless read. The pending request is dropped and no ack is issued.

Configuration
REQ-036 Macro RAM_ARB_TIMEOUT_EN defined: a counter runs in WAIT_READY. If TIMEOUT_CYCLES cycles elapse without synced ready, go to RESP with err=1 and data=0, leaving ramTriggerOut at its new level.
REQ-037 Macro RAM_ARB_TIMEOUT_EN undefined: there is no counter, and WAIT_READY waits indefinitely.

Verification
REQ-038 Fetch-only read of addr 0x10 holding 0xDEADBEEF -> fetchAckOut pulse in cycle N+6 with fetchDataOut=0xDEADBEEF and err=0; trigger toggles exactly once.
REQ-039 Data write 0x12345678 to 0x20, then fetch read of 0x20 -> fetchDataOut=0x12345678; ramRwOut=1 for the write and 0 for the read.
REQ-040 Both ports request in the same cycle and stay asserted for 4 transactions -> grant order fetch, data, fetch, data.
REQ-041 memAddrIn=0x3FE (1022) and memAddrIn=0x400 -> memErrOut=1 each, and ramTriggerOut never toggles.
REQ-042 nResetIn asserted during BLANK with ramTriggerOut=1 -> next cycle ramTriggerOut=0, ramRwOut=0, FSM IDLE, no ack; RAM contents unchanged.
REQ-043 With RAM_ARB_TIMEOUT_EN and ramReadyIn tied 0 -> ack with err=1 after BLANK plus 256 WAIT_READY cycles; without the macro, busyOut stays 1 indefinitely.
